// File: rtl/counter_access_arbiter_pkg.sv
// Shared encodings for the counter access arbiter: FSM states, op kinds, timer width.
package counter_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    typedef enum logic {
        OP_UP   = 1'b0,
        OP_DOWN = 1'b1
    } op_t;

    // Wide enough for TIMEOUT up to 15.
    localparam int TMR_W = 4;

endpackage

// File: rtl/counter_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending bit at or after ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && pending[idx]) begin
                valid = 1'b1;
                grant = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter sharing one up/down counter between NREQ requesters.
// `define COUNTER_ARB_SATURATE_EN refuses ops that would wrap the counter.
module counter_access_arbiter
    import counter_access_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req_up,
    input  logic [NREQ-1:0] req_down,
    output logic [NREQ-1:0] req_ack,
    output logic [NREQ-1:0] req_nack,
    output logic            cnt_up,
    output logic            cnt_down,
    input  logic            cnt_upAck,
    input  logic            cnt_downAck,
    input  logic [SIZE-1:0] cnt_value,
    output logic            busy,
    output logic            timeout_err
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    op_t             op;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic [TMR_W-1:0] timer;

    logic [NREQ-1:0] pending;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [IW-1:0]   next_ptr;
    logic            illegal;
    logic            sat_block;
    logic            match_ack;

    assign pending  = req_up | req_down;
    assign next_ptr = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
    assign illegal  = req_up[pick] & req_down[pick];
    assign match_ack = (op == OP_UP) ? cnt_upAck : cnt_downAck;
    assign busy     = (state != IDLE);

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .grant   (pick),
        .valid   (pick_vld)
    );

`ifdef COUNTER_ARB_SATURATE_EN
    assign sat_block = req_up[pick] ? (cnt_value == '1) : (cnt_value == '0);
`else
    logic unused_cnt_value;
    assign unused_cnt_value = ^cnt_value;
    assign sat_block = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            op          <= OP_UP;
            rr_ptr      <= '0;
            gidx        <= '0;
            timer       <= '0;
            cnt_up      <= 1'b0;
            cnt_down    <= 1'b0;
            req_ack     <= '0;
            req_nack    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gidx   <= pick;
                        rr_ptr <= next_ptr;
                        op     <= req_up[pick] ? OP_UP : OP_DOWN;
                        // Refused grants skip the counter entirely.
                        if (illegal || sat_block) begin
                            req_nack[pick] <= 1'b1;
                            state          <= RESP;
                        end else begin
                            cnt_up   <= req_up[pick];
                            cnt_down <= ~req_up[pick];
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_up   <= 1'b0;
                    cnt_down <= 1'b0;
                    timer    <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (match_ack) begin
                        req_ack[gidx] <= 1'b1;
                        state         <= RESP;
                    end else if (timer == TMR_W'(TIMEOUT)) begin
                        req_nack[gidx] <= 1'b1;
                        timeout_err    <= 1'b1;
                        state          <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    req_ack  <= '0;
                    req_nack <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    counter_arb_firewall #(.NREQ(NREQ)) u_fw (
        .clock    (clock),
        .reset    (reset),
        .cnt_up   (cnt_up),
        .cnt_down (cnt_down),
        .req_ack  (req_ack),
        .req_nack (req_nack)
    );

endmodule

// Protocol firewall: counter never sees both directions, at most one response per cycle.
module counter_arb_firewall #(
    parameter int NREQ = 4
) (
    input logic            clock,
    input logic            reset,
    input logic            cnt_up,
    input logic            cnt_down,
    input logic [NREQ-1:0] req_ack,
    input logic [NREQ-1:0] req_nack
);

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(cnt_up && cnt_down));
            assert ($onehot0(req_ack | req_nack));
        end
    end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Self-checking bench for counter_access_arbiter with a behavioural counter and RR reference model.
module tb_counter_access_arbiter;

    localparam int NREQ    = 4;
    localparam int SIZE    = 8;
    localparam int TIMEOUT = 7;
`ifdef COUNTER_ARB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NREQ-1:0] req_up = '0, req_down = '0;
    logic [NREQ-1:0] req_ack, req_nack;
    logic            cnt_up, cnt_down, busy, timeout_err;
    logic            cnt_upAck = 1'b0, cnt_downAck = 1'b0;
    logic [SIZE-1:0] cval = '0;
    logic            ack_en = 1'b1, load_en = 1'b0;
    logic [SIZE-1:0] load_val = '0;

    always #5 clock = ~clock;

    counter_access_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .req_up(req_up), .req_down(req_down),
        .req_ack(req_ack), .req_nack(req_nack), .cnt_up(cnt_up), .cnt_down(cnt_down),
        .cnt_upAck(cnt_upAck), .cnt_downAck(cnt_downAck), .cnt_value(cval),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Behavioural up/down counter: updates on the pulse, acks one cycle later.
    always @(posedge clock) begin
        if (load_en)       cval <= load_val;
        else if (cnt_up)   cval <= cval + 1'b1;
        else if (cnt_down) cval <= cval - 1'b1;
        cnt_upAck   <= cnt_up & ack_en;
        cnt_downAck <= cnt_down & ack_en;
    end

    int total = 0, passed = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic load(input logic [SIZE-1:0] v);
        load_en = 1'b1; load_val = v;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        req_up = '0; req_down = '0;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    // Reference model: expected service order, response kind, and spacing.
    int              m_ptr = 0;
    logic [SIZE-1:0] m_val;
    int              e_idx[$];
    bit              e_ack[$];
    int              e_dt[$];
    int              e_ups, e_dns;

    task automatic model(input logic [NREQ-1:0] up, input logic [NREQ-1:0] dn);
        logic [NREQ-1:0] pend;
        int i;
        pend = up | dn;
        e_idx.delete(); e_ack.delete(); e_dt.delete();
        e_ups = 0; e_dns = 0; i = 0;
        while (pend != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (pend[i]) break;
            end
            pend[i] = 1'b0;
            m_ptr = (i + 1) % NREQ;
            e_idx.push_back(i);
            if (up[i] && dn[i]) begin
                e_ack.push_back(1'b0); e_dt.push_back(2);
            end else if (up[i]) begin
                if (SAT && m_val == 8'hFF) begin
                    e_ack.push_back(1'b0); e_dt.push_back(2);
                end else begin
                    m_val = m_val + 1'b1; e_ups++;
                    e_ack.push_back(1'b1); e_dt.push_back(4);
                end
            end else begin
                if (SAT && m_val == 8'h00) begin
                    e_ack.push_back(1'b0); e_dt.push_back(2);
                end else begin
                    m_val = m_val - 1'b1; e_dns++;
                    e_ack.push_back(1'b1); e_dt.push_back(4);
                end
            end
        end
    endtask

    task automatic run_batch(input string tag, input logic [NREQ-1:0] up,
                             input logic [NREQ-1:0] dn, input logic [SIZE-1:0] start);
        int cyc, prev, n, nup, ndn;
        logic [NREQ-1:0] r;
        load(start);
        m_val = start;
        model(up, dn);
        req_up = up; req_down = dn;
        cyc = 0; prev = -1; n = 0; nup = 0; ndn = 0;
        while (n < e_idx.size() && cyc < 100) begin
            tick(); cyc++;
            nup += int'(cnt_up); ndn += int'(cnt_down);
            r = req_ack | req_nack;
            if (r != '0) begin
                check({tag, " who"},  r, 32'(1) << e_idx[n]);
                check({tag, " kind"}, req_ack != '0, e_ack[n]);
                check({tag, " gap"},  cyc - prev, e_dt[n]);
                prev = cyc; n++;
                req_up &= ~r; req_down &= ~r;
            end
        end
        check({tag, " served"}, n, e_idx.size());
        req_up = '0; req_down = '0;
        tick();
        check({tag, " value"}, cval, m_val);
        check({tag, " ups"},   nup, e_ups);
        check({tag, " downs"}, ndn, e_dns);
        check({tag, " idle"},  busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [NREQ-1:0] u, d;

        // Reset state
        load_en = 1'b1; load_val = 8'h05;
        tick(); tick();
        load_en = 1'b0;
        check("rst busy", busy, 0);
        check("rst up", cnt_up, 0);
        check("rst down", cnt_down, 0);
        check("rst ack", req_ack, 0);
        check("rst nack", req_nack, 0);
        check("rst terr", timeout_err, 0);
        reset = 1'b1;

        // Single up with exact latency
        req_up = 4'b0001;
        tick();
        check("t1 cnt_up c1", cnt_up, 1);
        check("t1 cnt_down c1", cnt_down, 0);
        check("t1 busy c1", busy, 1);
        tick();
        check("t1 cnt_up c2", cnt_up, 0);
        check("t1 ack c2", req_ack, 0);
        tick();
        check("t1 ack c3", req_ack, 4'b0001);
        req_up = '0;
        tick();
        check("t1 ack c4", req_ack, 0);
        check("t1 busy c4", busy, 0);
        check("t1 value", cval, 8'h06);

        // Illegal: both directions from one requester
        req_up = 4'b0001; req_down = 4'b0001;
        tick();
        check("t3 nack c1", req_nack, 4'b0001);
        check("t3 no up", cnt_up, 0);
        check("t3 no down", cnt_down, 0);
        req_up = '0; req_down = '0;
        tick(); tick();
        check("t3 value", cval, 8'h06);

        // Timeout with counter acks suppressed
        ack_en = 1'b0;
        req_down = 4'b0100;
        tick();
        check("t4 cnt_down c1", cnt_down, 1);
        cyc = 1;
        while (req_nack == '0 && cyc < 40) begin
            tick(); cyc++;
        end
        check("t4 nack cycle", cyc, 3 + TIMEOUT);
        check("t4 nack who", req_nack, 4'b0100);
        check("t4 terr", timeout_err, 1);
        req_down = '0; ack_en = 1'b1;
        tick(); tick();
        check("t4 terr sticky", timeout_err, 1);

        // Wrap or saturate at all-ones
        load(8'hFF);
        req_up = 4'b0001;
        cyc = 0;
        while ((req_ack | req_nack) == '0 && cyc < 20) begin
            tick(); cyc++;
        end
        check("t5 resp cycle", cyc, SAT ? 1 : 3);
        check("t5 ack", req_ack, SAT ? 4'b0000 : 4'b0001);
        check("t5 nack", req_nack, SAT ? 4'b0001 : 4'b0000);
        req_up = '0;
        tick(); tick();
        check("t5 value", cval, SAT ? 8'hFF : 8'h00);

        // Reset during WAIT
        req_up = 4'b0010;
        tick(); tick();
        check("t6 busy wait", busy, 1);
        reset = 1'b0;
        tick();
        check("t6 busy", busy, 0);
        check("t6 up", cnt_up, 0);
        check("t6 down", cnt_down, 0);
        check("t6 ack", req_ack, 0);
        check("t6 nack", req_nack, 0);
        check("t6 terr", timeout_err, 0);
        reset = 1'b1;
        req_up = '0;
        tick();
        m_ptr = 0;
        run_batch("t6 ptr", 4'b0110, 4'b0000, 8'h10);

        // Contention from a fresh pointer
        do_reset();
        m_ptr = 0;
        run_batch("t2 contend", 4'b1010, 4'b0100, 8'h40);

        // Randomized batches, edge values mixed in
        for (int t = 0; t < 30; t++) begin
            u = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            case (t % 5)
                0: run_batch("rnd", u, d, 8'hFF);
                1: run_batch("rnd", u, d, 8'h00);
                default: run_batch("rnd", u, d, 8'($urandom_range(0, 255)));
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
